iq_accumulator: RTL and testbench

Integrates signed ADC I/Q samples over a fixed-length readout window. Produces the packed `{Q,I}` sum word and a one-cycle `stb_start` strobe that drive the normalizer front end of the neural-network classifier. The block is the upstream producer of `accumulated_input`/`stb_start`. It owns window framing, sample counting and overflow handling.

---
 rtl/iq_accumulator.sv | 101 ++++++++++
 tb/tb_iq_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_accumulator.sv
// Windowed I/Q integrator: sums WINDOW_LEN valid ADC samples with per-add saturation
// and presents the packed {Q,I} result with a one-cycle strobe.
module iq_accumulator #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int WINDOW_LEN   = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trig,
    input  logic                     adc_valid,
    input  logic [SAMPLE_WIDTH-1:0]  adc_i,
    input  logic [SAMPLE_WIDTH-1:0]  adc_q,
    output logic [2*ACC_WIDTH-1:0]   accumulated_output,
    output logic                     stb_start,
    output logic                     busy,
    output logic                     sat_flag,
    output logic                     trig_overrun
);

    localparam int CNT_W = $clog2(WINDOW_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                   state;
    logic signed [ACC_WIDTH-1:0]  sum_i;
    logic signed [ACC_WIDTH-1:0]  sum_q;
    logic [CNT_W-1:0]             cnt;
    logic                         sat_work;

    // {saturated, result}: (ACC_WIDTH+1)-bit signed add clamped back to ACC_WIDTH bits.
    // Overflow shows up as disagreement between the two top bits of the wide sum.
    function automatic logic [ACC_WIDTH:0] sat_add(
        input logic signed [ACC_WIDTH-1:0]    acc,
        input logic signed [SAMPLE_WIDTH-1:0] smp
    );
        logic signed [ACC_WIDTH:0] wide;
        wide = $signed({acc[ACC_WIDTH-1], acc})
             + $signed({{(ACC_WIDTH+1-SAMPLE_WIDTH){smp[SAMPLE_WIDTH-1]}}, smp});
        if (wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1])
            return {1'b1, wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}};
        return {1'b0, wide[ACC_WIDTH-1:0]};
    endfunction

    logic [ACC_WIDTH:0] res_i;
    logic [ACC_WIDTH:0] res_q;

    assign res_i = sat_add(sum_i, $signed(adc_i));
    assign res_q = sat_add(sum_q, $signed(adc_q));

    assign busy      = (state == S_ACCUM);
    assign stb_start = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            sum_i              <= '0;
            sum_q              <= '0;
            cnt                <= '0;
            sat_work           <= 1'b0;
            accumulated_output <= '0;
            sat_flag           <= 1'b0;
            trig_overrun       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (trig) begin
                        sum_i    <= '0;
                        sum_q    <= '0;
                        cnt      <= '0;
                        sat_work <= 1'b0;
                        state    <= S_ACCUM;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (trig)
                        trig_overrun <= 1'b1;
                    if (adc_valid) begin
                        sum_i    <= res_i[ACC_WIDTH-1:0];
                        sum_q    <= res_q[ACC_WIDTH-1:0];
                        sat_work <= sat_work | res_i[ACC_WIDTH] | res_q[ACC_WIDTH];
                        cnt      <= cnt + CNT_W'(1);
                        // Final sample: publish sums including this add, counter never wraps.
                        if (cnt == LAST_CNT) begin
                            accumulated_output <= {res_q[ACC_WIDTH-1:0], res_i[ACC_WIDTH-1:0]};
                            sat_flag           <= sat_work | res_i[ACC_WIDTH] | res_q[ACC_WIDTH];
                            state              <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_accumulator.sv
// Scoreboard bench for iq_accumulator: stimulus pushes model results, a negedge monitor
// pops them whenever stb_start is seen.
module tb_iq_accumulator;

    localparam int SW = 16;
    localparam int AW = 18;
    localparam int WL = 8;
    localparam longint AMAX = (64'sd1 <<< (AW-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW-1));

    logic            clk = 1'b0;
    logic            rst_n;
    logic            trig;
    logic            adc_valid;
    logic [SW-1:0]   adc_i;
    logic [SW-1:0]   adc_q;
    logic [2*AW-1:0] acc_out;
    logic            stb_start;
    logic            busy;
    logic            sat_flag;
    logic            trig_overrun;

    iq_accumulator #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW), .WINDOW_LEN(WL)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .adc_valid(adc_valid),
        .adc_i(adc_i), .adc_q(adc_q), .accumulated_output(acc_out),
        .stb_start(stb_start), .busy(busy), .sat_flag(sat_flag),
        .trig_overrun(trig_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint si;
        longint sq;
        bit     sat;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              n_tests = 0;
    int              n_fail  = 0;
    int              win_i[WL];
    int              win_q[WL];
    logic [2*AW-1:0] held_out = '0;
    bit              held_sat = 1'b0;
    bit              exp_ovr  = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: integer sums clamped to the ACC_WIDTH signed range after every add.
    function automatic exp_t model();
        exp_t e;
        e.si = 0; e.sq = 0; e.sat = 1'b0;
        for (int k = 0; k < WL; k++) begin
            e.si += win_i[k];
            e.sq += win_q[k];
            if (e.si > AMAX) begin e.si = AMAX; e.sat = 1'b1; end
            if (e.si < AMIN) begin e.si = AMIN; e.sat = 1'b1; end
            if (e.sq > AMAX) begin e.sq = AMAX; e.sat = 1'b1; end
            if (e.sq < AMIN) begin e.sq = AMIN; e.sat = 1'b1; end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && stb_start) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_stb: stb_start=1, expected no window result (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum_i", $signed(acc_out[AW-1:0]), mon_e.si);
                check("sum_q", $signed(acc_out[2*AW-1:AW]), mon_e.sq);
                check("sat_flag", sat_flag, mon_e.sat);
                held_out = acc_out;
                held_sat = sat_flag;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        adc_i = 16'($urandom);
        adc_q = 16'($urandom);
    endtask

    // One cycle inside an open window: outputs must be held while busy.
    task automatic win_cycle(input bit valid, input int si, input int sq);
        check("busy_in_window", busy, 1);
        check("stb_in_window", stb_start, 0);
        check("out_held", acc_out, held_out);
        check("sat_held", sat_flag, held_sat);
        adc_valid = valid;
        if (valid) begin
            adc_i = 16'(si);
            adc_q = 16'(sq);
        end else begin
            rand_data();
        end
        tick();
        trig = 1'b0;
    endtask

    task automatic run_window(input int idle, input int gmin, input int gmax,
                              input int ovr_at, input int trig_smp);
        repeat (idle) begin
            check("busy_idle", busy, 0);
            trig = 1'b0;
            adc_valid = 1'($urandom);
            rand_data();
            tick();
        end
        trig = 1'b1;
        adc_valid = 1'b1;
        adc_i = 16'(trig_smp);
        adc_q = 16'($urandom);
        tick();
        trig = 1'b0;
        exp_q.push_back(model());
        for (int k = 0; k < WL; k++) begin
            int gaps;
            gaps = $urandom_range(gmax, gmin);
            if (k == ovr_at) begin
                trig = 1'b1;
                exp_ovr = 1'b1;
            end
            for (int g = 0; g < gaps; g++)
                win_cycle(1'b0, 0, 0);
            win_cycle(1'b1, win_i[k], win_q[k]);
        end
        adc_valid = 1'b0;
        check("stb_after_last", stb_start, 1);
        check("busy_falls", busy, 0);
        check("trig_overrun", trig_overrun, exp_ovr);
    endtask

    task automatic fill_rand(input int mode);
        logic [SW-1:0] r;
        for (int k = 0; k < WL; k++) begin
            r = 16'($urandom);
            case (mode)
                0: win_i[k] = int'($signed(r));
                1: win_i[k] = 32000 + int'(r % 768);
                default: win_i[k] = int'($signed(r)) / 256;
            endcase
            r = 16'($urandom);
            case (mode)
                1: win_q[k] = -32768 + int'(r % 768);
                default: win_q[k] = int'($signed(r));
            endcase
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, acc_out, 0);
        check({tag, "_stb"}, stb_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sat"}, sat_flag, 0);
        check({tag, "_ovr"}, trig_overrun, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        trig = 1'b0;
        adc_valid = 1'b0;
        adc_i = '0;
        adc_q = '0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic window, contiguous, I=500 on the trig cycle must be excluded
        win_i = '{10, -3, 7, 1, 0, 0, 0, 0};
        win_q = '{-100, 50, 0, 25, 0, 0, 0, 0};
        run_window(2, 0, 0, -1, 500);
        // Same samples with 3-cycle gaps
        run_window(1, 3, 3, -1, 500);
        // Saturation, then an all-zero window clears the sums and sat_flag
        for (int k = 0; k < WL; k++) begin win_i[k] = 32767; win_q[k] = -32768; end
        run_window(2, 0, 1, -1, 0);
        for (int k = 0; k < WL; k++) begin win_i[k] = 0; win_q[k] = 0; end
        run_window(1, 0, 0, -1, 1234);
        // Overrun mid-window followed by a back-to-back window
        fill_rand(2);
        run_window(1, 0, 2, 3, 77);
        fill_rand(0);
        run_window(0, 0, 1, -1, -9);

        // Reset mid-window after 2 of the samples
        trig = 1'b1;
        adc_valid = 1'b1;
        rand_data();
        tick();
        trig = 1'b0;
        win_cycle(1'b1, 1000, -1000);
        win_cycle(1'b1, 2000, -2000);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_ovr = 1'b0;
        held_out = '0;
        held_sat = 1'b0;
        repeat (2) tick();
        check_all_zero("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        win_i = '{1, 2, 3, 4, 5, 6, 7, 8};
        win_q = '{-1, -2, -3, -4, -5, -6, -7, -8};
        run_window(1, 0, 1, -1, 500);

        // Randomized windows: back-to-back, gaps, overruns, saturation-prone data
        for (int w = 0; w < 30; w++) begin
            fill_rand($urandom_range(2, 0));
            run_window($urandom_range(2, 0), 0, $urandom_range(3, 0),
                       ($urandom_range(4, 0) == 0) ? int'($urandom_range(WL-1, 0)) : -1,
                       int'($signed(16'($urandom))));
        end
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
